seg_scan_mux: RTL and testbench

Parametrised multiplexed seven-segment scanner that drives a common-segment display of `DIGITS` digits from packed hex nibbles. It sits between the clock/counter logic and the `which_light` / `digit_shape` pins of `design_top`, and generalises the fixed 4-digit scan. It adds:
- a configurable digit count;
- per-digit decimal points;
- leading-zero suppression;
- PWM brightness;
- per-bus output polarity;
- tear-free frame snapshotting.

---
 rtl/seg_scan_mux.sv | 173 +++++++++++++++++
 tb/tb_seg_scan_mux.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_mux.sv
// rtl/seg_scan_mux.sv - multiplexed seven-segment scanner with snapshot, blanking and PWM
//
// Scans DIGITS digits of a common-segment display, one digit slot of
// 2**BRIGHT_W clocks at a time, digit 0 (rightmost) first.
//
// Parameters:
//   DIGITS          number of digits scanned (2..8)
//   BRIGHT_W        brightness width; one slot lasts 2**BRIGHT_W clocks
//   SEG_ACTIVE_LOW  1: digit_shape driven inverted (0 = segment lit)
//   DIG_ACTIVE_LOW  1: which_light driven inverted (0 = digit selected)
//
// Ports:
//   clk          system clock
//   reset        synchronous active-high reset
//   digits_in    packed hex nibbles, nibble k = digit k
//   dp_in        decimal point request per digit
//   lz_suppress  leading-zero blanking enable
//   brightness   on-time per slot in clocks, minus one
//   enable       display enable, sampled every clock (not snapshotted)
//   which_light  registered one-hot digit select
//   digit_shape  registered segment bus {dp,g,f,e,d,c,b,a}

module seg_scan_mux #(
    parameter int DIGITS         = 4,
    parameter int BRIGHT_W       = 2,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   digits_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  lz_suppress,
    input  logic [BRIGHT_W-1:0]   brightness,
    input  logic                  enable,
    output logic [DIGITS-1:0]     which_light,
    output logic [7:0]            digit_shape
);

    localparam int              IDX_W    = $clog2(DIGITS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    // Scan position
    logic [BRIGHT_W-1:0] slot_q, slot_d;
    logic [IDX_W-1:0]    idx_q, idx_d;

    // Frame snapshot of the display content
    logic [4*DIGITS-1:0] dig_snap_q, dig_snap_d;
    logic [DIGITS-1:0]   dp_snap_q, dp_snap_d;
    logic                lz_snap_q, lz_snap_d;
    logic [BRIGHT_W-1:0] br_snap_q, br_snap_d;

    // Registered output buses
    logic [DIGITS-1:0]   which_q, which_d;
    logic [7:0]          shape_q, shape_d;

    // Decode helpers
    logic                frame_start;
    logic [DIGITS-1:0]   blank;
    logic [DIGITS-1:0]   sel;
    logic                any_set;
    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic                cur_blank;
    logic                lit;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0: pat = 7'h3F;
            4'h1: pat = 7'h06;
            4'h2: pat = 7'h5B;
            4'h3: pat = 7'h4F;
            4'h4: pat = 7'h66;
            4'h5: pat = 7'h6D;
            4'h6: pat = 7'h7D;
            4'h7: pat = 7'h07;
            4'h8: pat = 7'h7F;
            4'h9: pat = 7'h6F;
            4'hA: pat = 7'h77;
            4'hB: pat = 7'h7C;
            4'hC: pat = 7'h39;
            4'hD: pat = 7'h5E;
            4'hE: pat = 7'h79;
            default: pat = 7'h71;
        endcase
        return pat;
    endfunction

    // Counters and snapshot capture
    always_comb begin
        slot_d      = slot_q + BRIGHT_W'(1);
        idx_d       = idx_q;
        frame_start = (idx_q == '0) && (slot_q == '0);

        if (slot_q == '1) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end

        dig_snap_d = dig_snap_q;
        dp_snap_d  = dp_snap_q;
        lz_snap_d  = lz_snap_q;
        br_snap_d  = br_snap_q;
        if (frame_start) begin
            dig_snap_d = digits_in;
            dp_snap_d  = dp_in;
            lz_snap_d  = lz_suppress;
            br_snap_d  = brightness;
        end
    end

    // Leading-zero mask, built from the top digit down. A set dp or a
    // nonzero nibble at or above k stops blanking of digit k. The *_d
    // snapshot is used so digit 0 of a new frame already sees fresh data.
    always_comb begin
        any_set = 1'b0;
        blank   = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            any_set  = any_set | (dig_snap_d[4*k +: 4] != 4'h0) | dp_snap_d[k];
            blank[k] = lz_snap_d && (k != 0) && !any_set;
        end
    end

    // Current digit selection and output formation
    always_comb begin
        sel       = '0;
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                sel[k]    = 1'b1;
                cur_nib   = dig_snap_d[4*k +: 4];
                cur_dp    = dp_snap_d[k];
                cur_blank = blank[k];
            end
        end

        lit = enable && (slot_q <= br_snap_d);

        which_d = lit ? sel : '0;
        shape_d = lit ? {cur_dp, (cur_blank ? 7'h00 : seg_decode(cur_nib))} : 8'h00;

        which_d = which_d ^ {DIGITS{DIG_ACTIVE_LOW}};
        shape_d = shape_d ^ {8{SEG_ACTIVE_LOW}};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_q     <= '0;
            idx_q      <= '0;
            dig_snap_q <= '0;
            dp_snap_q  <= '0;
            lz_snap_q  <= 1'b0;
            br_snap_q  <= '0;
            which_q    <= {DIGITS{DIG_ACTIVE_LOW}};
            shape_q    <= {8{SEG_ACTIVE_LOW}};
        end else begin
            slot_q     <= slot_d;
            idx_q      <= idx_d;
            dig_snap_q <= dig_snap_d;
            dp_snap_q  <= dp_snap_d;
            lz_snap_q  <= lz_snap_d;
            br_snap_q  <= br_snap_d;
            which_q    <= which_d;
            shape_q    <= shape_d;
        end
    end

    assign which_light = which_q;
    assign digit_shape = shape_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb/tb_seg_scan_mux.sv - randomized bench for seg_scan_mux against a frame-position model

module tb_seg_scan_mux;

    logic        clk = 1'b0;
    logic        reset;

    // Instance A: 4 digits, 4-clock slots, active-low buses
    logic [15:0] dig_a;
    logic [3:0]  dp_a;
    logic        lz_a;
    logic [1:0]  br_a;
    logic        en_a;
    logic [3:0]  wl_a;
    logic [7:0]  ds_a;

    // Instance B: 8 digits, 8-clock slots, active-high buses
    logic [31:0] dig_b;
    logic [7:0]  dp_b;
    logic        lz_b;
    logic [2:0]  br_b;
    logic        en_b;
    logic [7:0]  wl_b;
    logic [7:0]  ds_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg_scan_mux #(.DIGITS(4), .BRIGHT_W(2), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)) u_dut_a (
        .clk(clk), .reset(reset), .digits_in(dig_a), .dp_in(dp_a), .lz_suppress(lz_a),
        .brightness(br_a), .enable(en_a), .which_light(wl_a), .digit_shape(ds_a)
    );

    seg_scan_mux #(.DIGITS(8), .BRIGHT_W(3), .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)) u_dut_b (
        .clk(clk), .reset(reset), .digits_in(dig_b), .dp_in(dp_b), .lz_suppress(lz_b),
        .brightness(br_b), .enable(en_b), .which_light(wl_b), .digit_shape(ds_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_pat(input logic [3:0] n);
        logic [6:0] t [16];
        t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return t[n];
    endfunction

    // Expected {which_light(8b), digit_shape} for a position within the frame
    function automatic logic [15:0] model(input int d, input int s, input bit seg_low, input bit dig_low,
                                          input int pos, input logic [31:0] dig, input logic [7:0] dp,
                                          input bit lz, input int br, input bit en);
        int         idx;
        int         slot;
        logic [7:0] wl;
        logic [7:0] ds;
        logic [3:0] nib;
        bit         supp;
        idx = pos / s;
        slot = pos % s;
        wl = 8'h00;
        ds = 8'h00;
        if (en && slot <= br) begin
            wl = 8'(1 << idx);
            nib = 4'(dig >> (4 * idx));
            supp = lz && (idx != 0);
            for (int j = idx; j < d; j++) begin
                if (((dig >> (4 * j)) & 32'hF) != 0 || dp[j]) supp = 0;
            end
            ds = {dp[idx], supp ? 7'h00 : seg_pat(nib)};
        end
        if (dig_low) wl = ~wl & 8'((1 << d) - 1);
        if (seg_low) ds = ~ds;
        return {wl, ds};
    endfunction

    // Reference state: cycles since reset release and frame snapshots
    int          cnt_a, cnt_b;
    int          pos_a, pos_b;
    bit          ready_a = 0, ready_b = 0;
    logic [15:0] exp_a, exp_b;
    logic [31:0] sdig_a, sdig_b;
    logic [7:0]  sdp_a, sdp_b;
    bit          slz_a, slz_b;
    int          sbr_a, sbr_b;

    always @(posedge clk) begin
        if (reset) begin
            cnt_a = 0;
            ready_a = 1;
            exp_a = {8'h0F, 8'hFF};
        end else if (ready_a) begin
            pos_a = cnt_a % 16;
            if (pos_a == 0) begin
                sdig_a = {16'h0, dig_a};
                sdp_a = {4'h0, dp_a};
                slz_a = lz_a;
                sbr_a = int'(br_a);
            end
            exp_a = model(4, 4, 1, 1, pos_a, sdig_a, sdp_a, slz_a, sbr_a, en_a);
            cnt_a++;
        end
        #1;
        if (ready_a) begin
            check("a_which_light", {28'h0, wl_a}, {24'h0, exp_a[15:8]});
            check("a_digit_shape", {24'h0, ds_a}, {24'h0, exp_a[7:0]});
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            cnt_b = 0;
            ready_b = 1;
            exp_b = 16'h0000;
        end else if (ready_b) begin
            pos_b = cnt_b % 64;
            if (pos_b == 0) begin
                sdig_b = dig_b;
                sdp_b = dp_b;
                slz_b = lz_b;
                sbr_b = int'(br_b);
            end
            exp_b = model(8, 8, 0, 0, pos_b, sdig_b, sdp_b, slz_b, sbr_b, en_b);
            cnt_b++;
        end
        #1;
        if (ready_b) begin
            check("b_which_light", {24'h0, wl_b}, {24'h0, exp_b[15:8]});
            check("b_digit_shape", {24'h0, ds_b}, {24'h0, exp_b[7:0]});
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    logic [63:0] m;

    initial begin
        reset = 1'b1;
        dig_a = 16'h1234; dp_a = 4'h0; lz_a = 1'b0; br_a = 2'd3; en_a = 1'b1;
        dig_b = 32'hFEDCBA98; dp_b = 8'h00; lz_b = 1'b0; br_b = 3'd7; en_b = 1'b1;
        step(2);
        check("rst_a_wl", {28'h0, wl_a}, 32'hF);
        check("rst_a_ds", {24'h0, ds_a}, 32'hFF);
        check("rst_b_wl", {24'h0, wl_b}, 32'h00);
        check("rst_b_ds", {24'h0, ds_b}, 32'h00);
        reset = 1'b0;

        // Basic scan and wide-parameter frame
        for (int e = 1; e <= 65; e++) begin
            step(1);
            case (e)
                1: begin
                    check("scan_a_d0_wl", {28'h0, wl_a}, 32'hE);
                    check("scan_a_d0_ds", {24'h0, ds_a}, 32'h99);
                    check("scan_b_d0_wl", {24'h0, wl_b}, 32'h01);
                    check("scan_b_d0_ds", {24'h0, ds_b}, 32'h7F);
                end
                5: begin
                    check("scan_a_d1_wl", {28'h0, wl_a}, 32'hD);
                    check("scan_a_d1_ds", {24'h0, ds_a}, 32'hB0);
                end
                9: begin
                    check("scan_a_d2_wl", {28'h0, wl_a}, 32'hB);
                    check("scan_a_d2_ds", {24'h0, ds_a}, 32'hA4);
                end
                13: begin
                    check("scan_a_d3_wl", {28'h0, wl_a}, 32'h7);
                    check("scan_a_d3_ds", {24'h0, ds_a}, 32'hF9);
                end
                57: begin
                    check("sweep_b_d7_wl", {24'h0, wl_b}, 32'h80);
                    check("sweep_b_d7_ds", {24'h0, ds_b}, 32'h71);
                end
                65: begin
                    check("sweep_b_wrap_wl", {24'h0, wl_b}, 32'h01);
                    check("sweep_b_wrap_ds", {24'h0, ds_b}, 32'h7F);
                end
                default: ;
            endcase
        end

        // Minimum brightness
        br_a = 2'd0; br_b = 3'd0;
        step(48);

        // Leading-zero suppression, then dp ending suppression
        br_a = 2'd3; br_b = 3'd5;
        dig_a = 16'h0050; lz_a = 1'b1;
        dig_b = 32'h00000050; lz_b = 1'b1;
        step(64);
        dp_a = 4'b0100; dp_b = 8'b0000_0100;
        step(64);

        // Mid-frame content change while digit 2 is scanned
        dp_a = 4'h0; lz_a = 1'b0; dig_a = 16'h1234;
        step(32);
        for (int i = 0; i < 16 && (cnt_a % 16) != 9; i++) step(1);
        dig_a = 16'h9999;
        step(40);

        // Enable dropped for 3 clocks
        en_a = 1'b0; en_b = 1'b0;
        step(3);
        en_a = 1'b1; en_b = 1'b1;
        step(10);

        // Reset in the middle of a slot
        reset = 1'b1;
        step(1);
        check("midrst_a_wl", {28'h0, wl_a}, 32'hF);
        check("midrst_a_ds", {24'h0, ds_a}, 32'hFF);
        check("midrst_b_wl", {24'h0, wl_b}, 32'h00);
        reset = 1'b0;
        step(20);

        // Randomized run
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                m = (64'd1 << (4 * $urandom_range(0, 4))) - 64'd1;
                dig_a = 16'($urandom) & m[15:0];
                m = (64'd1 << (4 * $urandom_range(0, 8))) - 64'd1;
                dig_b = $urandom & m[31:0];
            end
            if ($urandom_range(0, 15) == 0) begin
                dp_a = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'(1 << $urandom_range(0, 3));
                dp_b = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
            end
            if ($urandom_range(0, 15) == 0) begin
                lz_a = 1'($urandom);
                lz_b = 1'($urandom);
            end
            if ($urandom_range(0, 15) == 0) begin
                br_a = 2'($urandom);
                br_b = 3'($urandom);
            end
            en_a = ($urandom_range(0, 19) != 0);
            en_b = ($urandom_range(0, 19) != 0);
            reset = ($urandom_range(0, 299) == 0);
            step(1);
        end
        reset = 1'b0;
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
